alu_result_checker: RTL and testbench
=====================================

Name: alu_result_checker

Overview:
- Hardware scoreboard at the consuming end of the 64-bit ALU interface.
- Accepts ALU transactions over a valid/ready handshake. Each transaction carries the operands, cntrl, the result and the four flags.
- Recomputes the golden result and flags internally, compares them against the received values, and keeps pass/fail counts plus a record of the first failure.
- Used for on-chip self-test and in regression benches behind the ALU.

Parameters:
WIDTH, 64, datapath width of A, B and result
CNT_W, 16, width of vector index and counters

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous, active-low reset
start  in  1  pulse; begin a run of num_vectors transactions
clear  in  1  synchronous; abort run, zero all status, go IDLE
num_vectors  in  CNT_W  number of transactions in the run; sampled on start
in_valid  in  1  transaction present
in_ready  out  1  checker accepts transaction this cycle
in_A  in  WIDTH  operand A
in_B  in  WIDTH  operand B
in_cntrl  in  3  op code: 000 pass B, 010 add, 011 sub, 100 and, 101 or, 110 xor
in_result  in  WIDTH  ALU result under test
in_negative, in_zero, in_overflow, in_carry_out  in  1 each  ALU flags under test
busy  out  1  state is RUN
done  out  1  state is DONE
pass_count  out  CNT_W  transactions that matched
fail_count  out  CNT_W  transactions that mismatched
err_sticky  out  1  set on any failure; cleared only by start, clear or reset
first_fail_idx  out  CNT_W  index (0-based) of first failing transaction
first_fail_cntrl  out  3  cntrl of first failing transaction
first_fail_reason  out  6  bit0 result, bit1 negative, bit2 zero, bit3 overflow, bit4 carry_out, bit5 illegal cntrl

Behaviour:
- Reset:
  - State goes to IDLE immediately.
  - All outputs and counters are 0; in_ready is 0.
  - Any in-flight transaction is discarded.
- States: IDLE, RUN, DRAIN, DONE.
  - start in IDLE or DONE: zero counters, err_sticky and first_fail_*; latch num_vectors; accept index = 0. Go to RUN, or to DONE next cycle if num_vectors = 0.
  - start in RUN or DRAIN: ignored.
  - clear: highest priority after reset. From any state, go to IDLE and zero all status.
  - RUN: in_ready = 1 while accepted < num_vectors. A transfer occurs when in_valid && in_ready. Transfer of the last vector moves the state to DRAIN.
  - DRAIN: in_ready = 0. After the last compare commits, go to DONE.
  - DONE: hold until start or clear.
- Pipeline:
  - Stage 1 registers the accepted transaction and its index.
  - Stage 2 computes the expected values, compares them and commits.
  - A transfer at edge N updates the counters at edge N+1.
  - done is asserted from edge N+2, where N is the last transfer edge.
  - Full throughput: one transaction per cycle, no bubbles.
- Golden model (WIDTH-bit, two's complement):
  - 000: R = B.
  - 010: {C, R} = A + B.
  - 011: {C, R} = A + ~B + 1, so C = 1 exactly when A >= B unsigned.
  - 100: R = A & B. 101: R = A | B. 110: R = A ^ B.
  - Overflow for add: A[msb] == B[msb] and R[msb] != A[msb].
  - Overflow for sub: A[msb] != B[msb] and R[msb] != A[msb].
  - negative = R[msb]; zero = (R == 0).
- Compare rules:
  - result, negative and zero are checked for all legal ops.
  - overflow and carry_out are checked only for 010 and 011; otherwise they are don't-care.
  - cntrl 001 or 111 is an illegal op: fail with reason bit5 only, no other compare.
- Counters saturate at all-ones and do not wrap.
- first_fail_* is written only on the first failure of a run, and only when err_sticky was 0.

Test Plan:
- Reset, start num=3. Send add 1+1 → 2, flags 0000; add 7FFF…F + 8000…1 → 0, carry 1, zero 1; add 7FFF…F + 1 → 8000…0, ovf 1, neg 1. Expect pass_count=3, fail_count=0, err_sticky=0, done=1 two cycles after the 3rd transfer.
- Sub 1−1 reported with result 0, zero 1, carry 0 (carry should be 1). Expect fail_count=1, first_fail_idx=0, first_fail_cntrl=011, first_fail_reason=010000.
- Pass B with B=8000…0, neg 1, zero 0, and random ovf/carry. Expect pass; also confirm carry/ovf are ignored for and/or/xor.
- cntrl=111 followed by a valid xor vector. Expect fail_count=1, pass_count=1, reason=100000, first_fail_idx=0.
- num=4 with in_valid held high continuously. Expect exactly 4 transfers, in_ready falling the cycle after the 4th, and extra vectors not counted. num=0 → done one cycle after start.
- rst_n low mid-run after 2 transfers. Expect all outputs 0 immediately. clear mid-run → IDLE, counters 0 on the next edge.

Source files
------------

// File: rtl/alu_result_checker.sv
// Scoreboard for the 64-bit ALU interface. It accepts transactions over a
// valid/ready handshake, recomputes the expected result and flags, and
// records pass/fail counts plus details of the first failure in each run.
module alu_result_checker #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             clear,
  input  logic [CNT_W-1:0] num_vectors,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_A,
  input  logic [WIDTH-1:0] in_B,
  input  logic [2:0]       in_cntrl,
  input  logic [WIDTH-1:0] in_result,
  input  logic             in_negative,
  input  logic             in_zero,
  input  logic             in_overflow,
  input  logic             in_carry_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] fail_count,
  output logic             err_sticky,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic [2:0]       first_fail_cntrl,
  output logic [5:0]       first_fail_reason
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t state, state_next;

  logic [CNT_W-1:0] num_q;
  logic [CNT_W-1:0] acc_idx;
  logic             xfer;
  logic             start_ok;

  logic             s1_valid;
  logic [CNT_W-1:0] s1_idx;
  logic [WIDTH-1:0] s1_a, s1_b, s1_result;
  logic [2:0]       s1_cntrl;
  logic             s1_negative, s1_zero, s1_overflow, s1_carry;

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] exp_r;
  logic             exp_c, exp_v, legal, arith;
  logic [5:0]       reason;

  assign in_ready = (state == RUN) && (acc_idx < num_q);
  assign xfer     = in_valid && in_ready;
  assign start_ok = start && ((state == IDLE) || (state == DONE));
  assign busy     = (state == RUN);
  assign done     = (state == DONE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; clear overrides everything, start only from IDLE/DONE
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (start) state_next = (num_vectors == '0) ? DONE : RUN;
      RUN:        if (xfer && (acc_idx == num_q - CNT_W'(1))) state_next = DRAIN;
      DRAIN:      if (!s1_valid) state_next = DONE;
      default:    state_next = IDLE;
    endcase
    if (clear) state_next = IDLE;
  end

  // Accept index, run length and stage-1 transaction register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_q       <= '0;
      acc_idx     <= '0;
      s1_valid    <= 1'b0;
      s1_idx      <= '0;
      s1_a        <= '0;
      s1_b        <= '0;
      s1_result   <= '0;
      s1_cntrl    <= '0;
      s1_negative <= 1'b0;
      s1_zero     <= 1'b0;
      s1_overflow <= 1'b0;
      s1_carry    <= 1'b0;
    end else if (clear) begin
      num_q    <= '0;
      acc_idx  <= '0;
      s1_valid <= 1'b0;
    end else begin
      if (start_ok) begin
        num_q   <= num_vectors;
        acc_idx <= '0;
      end else if (xfer) begin
        acc_idx <= acc_idx + CNT_W'(1);
      end
      s1_valid <= xfer;
      if (xfer) begin
        s1_idx      <= acc_idx;
        s1_a        <= in_A;
        s1_b        <= in_B;
        s1_result   <= in_result;
        s1_cntrl    <= in_cntrl;
        s1_negative <= in_negative;
        s1_zero     <= in_zero;
        s1_overflow <= in_overflow;
        s1_carry    <= in_carry_out;
      end
    end
  end

  // Golden model and compare for the stage-1 transaction
  always_comb begin
    sum   = '0;
    exp_r = '0;
    exp_c = 1'b0;
    exp_v = 1'b0;
    legal = 1'b1;
    arith = 1'b0;
    case (s1_cntrl)
      3'b000: exp_r = s1_b;
      3'b010: begin
        sum   = {1'b0, s1_a} + {1'b0, s1_b};
        exp_r = sum[WIDTH-1:0];
        exp_c = sum[WIDTH];
        exp_v = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) && (exp_r[WIDTH-1] != s1_a[WIDTH-1]);
        arith = 1'b1;
      end
      3'b011: begin
        sum   = {1'b0, s1_a} + {1'b0, ~s1_b} + (WIDTH+1)'(1);
        exp_r = sum[WIDTH-1:0];
        exp_c = sum[WIDTH];
        exp_v = (s1_a[WIDTH-1] != s1_b[WIDTH-1]) && (exp_r[WIDTH-1] != s1_a[WIDTH-1]);
        arith = 1'b1;
      end
      3'b100:  exp_r = s1_a & s1_b;
      3'b101:  exp_r = s1_a | s1_b;
      3'b110:  exp_r = s1_a ^ s1_b;
      default: legal = 1'b0;
    endcase
    reason = '0;
    if (!legal) begin
      reason[5] = 1'b1;
    end else begin
      reason[0] = (s1_result != exp_r);
      reason[1] = (s1_negative != exp_r[WIDTH-1]);
      reason[2] = (s1_zero != (exp_r == '0));
      reason[3] = arith && (s1_overflow != exp_v);
      reason[4] = arith && (s1_carry != exp_c);
    end
  end

  // Commit compare outcome into saturating counters and first-fail record
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_count        <= '0;
      fail_count        <= '0;
      err_sticky        <= 1'b0;
      first_fail_idx    <= '0;
      first_fail_cntrl  <= '0;
      first_fail_reason <= '0;
    end else if (clear || start_ok) begin
      pass_count        <= '0;
      fail_count        <= '0;
      err_sticky        <= 1'b0;
      first_fail_idx    <= '0;
      first_fail_cntrl  <= '0;
      first_fail_reason <= '0;
    end else if (s1_valid) begin
      if (reason == '0) begin
        if (pass_count != '1) pass_count <= pass_count + CNT_W'(1);
      end else begin
        if (fail_count != '1) fail_count <= fail_count + CNT_W'(1);
        err_sticky <= 1'b1;
        if (!err_sticky) begin
          first_fail_idx    <= s1_idx;
          first_fail_cntrl  <= s1_cntrl;
          first_fail_reason <= reason;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_result_checker.sv
// Directed bench for alu_result_checker with hand-computed expectations.
module tb_alu_result_checker;

  localparam int WIDTH = 64;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             clear = 1'b0;
  logic [CNT_W-1:0] num_vectors = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_A = '0, in_B = '0, in_result = '0;
  logic [2:0]       in_cntrl = '0;
  logic             in_negative = 1'b0, in_zero = 1'b0, in_overflow = 1'b0, in_carry_out = 1'b0;
  logic             busy, done, err_sticky;
  logic [CNT_W-1:0] pass_count, fail_count, first_fail_idx;
  logic [2:0]       first_fail_cntrl;
  logic [5:0]       first_fail_reason;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_result_checker #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .num_vectors(num_vectors),
    .in_valid(in_valid), .in_ready(in_ready), .in_A(in_A), .in_B(in_B), .in_cntrl(in_cntrl),
    .in_result(in_result), .in_negative(in_negative), .in_zero(in_zero),
    .in_overflow(in_overflow), .in_carry_out(in_carry_out), .busy(busy), .done(done),
    .pass_count(pass_count), .fail_count(fail_count), .err_sticky(err_sticky),
    .first_fail_idx(first_fail_idx), .first_fail_cntrl(first_fail_cntrl),
    .first_fail_reason(first_fail_reason)
  );

  // Pulse start for one cycle; returns at the negedge after the start edge.
  task automatic do_start(input logic [CNT_W-1:0] n);
    @(negedge clk);
    start = 1'b1;
    num_vectors = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Present one vector, wait (bounded) for ready, transfer on the next edge.
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic [2:0] c, input logic [WIDTH-1:0] r,
                      input logic n, input logic z, input logic v, input logic co);
    int t;
    t = 0;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      errors++;
      checks++;
      $display("FAIL send_ready: in_ready=%0b after %0d cycles, required 1", in_ready, t);
    end
    in_A = a; in_B = b; in_cntrl = c; in_result = r;
    in_negative = n; in_zero = z; in_overflow = v; in_carry_out = co;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 20 && !done; i++) @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s_done_timeout: done=%0b, required 1", name, done);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, in_ready, err_sticky} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: busy/done/ready/err=%b, required 0000", {busy, done, in_ready, err_sticky});
    end
    checks++;
    if ({pass_count, fail_count, first_fail_idx, first_fail_cntrl, first_fail_reason} !== '0) begin
      errors++;
      $display("FAIL reset_counts: pass=%0d fail=%0d idx=%0d, required 0", pass_count, fail_count, first_fail_idx);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add_pass();
    do_start(3);
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL add_run: busy=%0b ready=%0b, required 1 1", busy, in_ready);
    end
    send(64'd1, 64'd1, 3'b010, 64'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    send(64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 3'b010, 64'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    send(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 3'b010, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b1, 1'b0);
    // between last transfer edge N and N+1
    checks++;
    if (in_ready !== 1'b0 || done !== 1'b0 || pass_count !== 16'd2) begin
      errors++;
      $display("FAIL add_drain: ready=%0b done=%0b pass=%0d, required 0 0 2", in_ready, done, pass_count);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || pass_count !== 16'd3) begin
      errors++;
      $display("FAIL add_commit: done=%0b pass=%0d, required 0 3", done, pass_count);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || pass_count !== 16'd3 || fail_count !== 16'd0 || err_sticky !== 1'b0) begin
      errors++;
      $display("FAIL add_done: done=%0b pass=%0d fail=%0d err=%0b, required 1 3 0 0",
               done, pass_count, fail_count, err_sticky);
    end
  endtask

  task automatic test_sub_carry_fail();
    do_start(1);
    send(64'd1, 64'd1, 3'b011, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    wait_done("sub");
    checks++;
    if (fail_count !== 16'd1 || pass_count !== 16'd0 || err_sticky !== 1'b1) begin
      errors++;
      $display("FAIL sub_counts: pass=%0d fail=%0d err=%0b, required 0 1 1", pass_count, fail_count, err_sticky);
    end
    checks++;
    if (first_fail_idx !== 16'd0 || first_fail_cntrl !== 3'b011 || first_fail_reason !== 6'b010000) begin
      errors++;
      $display("FAIL sub_first: idx=%0d cntrl=%b reason=%b, required 0 011 010000",
               first_fail_idx, first_fail_cntrl, first_fail_reason);
    end
  endtask

  task automatic test_logic_ops();
    do_start(6);
    checks++;
    if (err_sticky !== 1'b0 || fail_count !== 16'd0) begin
      errors++;
      $display("FAIL start_clears: err=%0b fail=%0d, required 0 0", err_sticky, fail_count);
    end
    send(64'h1234, 64'h8000_0000_0000_0000, 3'b000, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b1, 1'b0);
    send(64'hFFFF_0000_FFFF_0000, 64'h0F0F_0F0F_0F0F_0F0F, 3'b100, 64'h0F0F_0000_0F0F_0000, 1'b0, 1'b0, 1'b1, 1'b1);
    send(64'hFFFF_0000_FFFF_0000, 64'h0F0F_0F0F_0F0F_0F0F, 3'b101, 64'hFFFF_0F0F_FFFF_0F0F, 1'b1, 1'b0, 1'b0, 1'b1);
    send(64'hFFFF_0000_FFFF_0000, 64'h0F0F_0F0F_0F0F_0F0F, 3'b110, 64'hF0F0_0F0F_F0F0_0F0F, 1'b1, 1'b0, 1'b1, 1'b0);
    send(64'd5, 64'd7, 3'b011, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 1'b0, 1'b0);
    send(64'h8000_0000_0000_0000, 64'd1, 3'b011, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b1);
    wait_done("logic");
    checks++;
    if (pass_count !== 16'd6 || fail_count !== 16'd0 || err_sticky !== 1'b0) begin
      errors++;
      $display("FAIL logic_counts: pass=%0d fail=%0d err=%0b, required 6 0 0", pass_count, fail_count, err_sticky);
    end
  endtask

  task automatic test_illegal();
    do_start(3);
    send(64'd3, 64'd4, 3'b111, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    send(64'hFF, 64'h0F, 3'b110, 64'hF0, 1'b0, 1'b0, 1'b0, 1'b0);
    send(64'hFF, 64'h0F, 3'b100, 64'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_done("illegal");
    checks++;
    if (fail_count !== 16'd2 || pass_count !== 16'd1) begin
      errors++;
      $display("FAIL illegal_counts: pass=%0d fail=%0d, required 1 2", pass_count, fail_count);
    end
    checks++;
    if (first_fail_idx !== 16'd0 || first_fail_cntrl !== 3'b111 || first_fail_reason !== 6'b100000) begin
      errors++;
      $display("FAIL illegal_first: idx=%0d cntrl=%b reason=%b, required 0 111 100000",
               first_fail_idx, first_fail_cntrl, first_fail_reason);
    end
  endtask

  task automatic test_back_to_back();
    int xfers;
    int ready_after;
    xfers = 0;
    ready_after = 0;
    do_start(4);
    in_A = 64'd1; in_B = 64'd1; in_cntrl = 3'b010; in_result = 64'd2;
    in_negative = 1'b0; in_zero = 1'b0; in_overflow = 1'b0; in_carry_out = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (in_ready && in_valid) xfers++;
      if (i == 4) ready_after = int'(in_ready);
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++;
    if (xfers !== 4) begin
      errors++;
      $display("FAIL b2b_xfers: transfers=%0d, required 4", xfers);
    end
    checks++;
    if (ready_after !== 0) begin
      errors++;
      $display("FAIL b2b_ready_fall: in_ready=%0d after 4th transfer, required 0", ready_after);
    end
    checks++;
    if (pass_count !== 16'd4 || done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_counts: pass=%0d done=%0b, required 4 1", pass_count, done);
    end
    do_start(0);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || pass_count !== 16'd0) begin
      errors++;
      $display("FAIL zero_run: done=%0b busy=%0b pass=%0d, required 1 0 0", done, busy, pass_count);
    end
  endtask

  task automatic test_reset_clear_midrun();
    do_start(4);
    send(64'd1, 64'd1, 3'b010, 64'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    send(64'd2, 64'd2, 3'b010, 64'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (pass_count !== 16'd1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: pass=%0d busy=%0b, required 1 1", pass_count, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, in_ready, err_sticky, pass_count, fail_count} !== '0) begin
      errors++;
      $display("FAIL async_reset: busy=%0b done=%0b ready=%0b pass=%0d, required all 0",
               busy, done, in_ready, pass_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (pass_count !== 16'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: pass=%0d busy=%0b, required 0 0", pass_count, busy);
    end
    do_start(4);
    send(64'd1, 64'd1, 3'b010, 64'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    send(64'd2, 64'd2, 3'b010, 64'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (fail_count !== 16'd1 || err_sticky !== 1'b1) begin
      errors++;
      $display("FAIL pre_clear: fail=%0d err=%0b, required 1 1", fail_count, err_sticky);
    end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    checks++;
    if ({busy, done, in_ready, err_sticky} !== 4'b0000 ||
        {pass_count, fail_count, first_fail_idx, first_fail_cntrl, first_fail_reason} !== '0) begin
      errors++;
      $display("FAIL clear_midrun: busy=%0b done=%0b ready=%0b err=%0b pass=%0d fail=%0d reason=%b, required all 0",
               busy, done, in_ready, err_sticky, pass_count, fail_count, first_fail_reason);
    end
    @(negedge clk);
    checks++;
    if (pass_count !== 16'd0 || fail_count !== 16'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL clear_settled: pass=%0d fail=%0d busy=%0b, required 0 0 0", pass_count, fail_count, busy);
    end
  endtask

  initial begin
    test_reset();
    test_add_pass();
    test_sub_carry_fail();
    test_logic_ops();
    test_illegal();
    test_back_to_back();
    test_reset_clear_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
